// File: rtl/fb_fill_pkg.sv
// Shared types for the framebuffer fill engine: FSM state encoding and the
// parameter set latched on start.
package fb_fill_pkg;

  localparam int FB_ADDR_BITS   = 24;
  localparam int FB_DIM_BITS    = 11;
  localparam int FB_STRIDE_BITS = 12;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  typedef struct packed {
    logic [FB_ADDR_BITS-1:0]   base;
    logic [FB_DIM_BITS-1:0]    width;
    logic [FB_DIM_BITS-1:0]    height;
    logic [FB_STRIDE_BITS-1:0] stride;
    logic [15:0]               data;
    logic [1:0]                mask;
  } fill_params_t;

endpackage

// File: rtl/fb_fill_dma_if.sv
// Write-only SDRAM arbiter port: command handshake plus in-order write acks.
interface fb_fill_dma_if #(
  parameter int ADDR_BITS = 24
);
  logic                 sdram_cmd_valid;
  logic                 sdram_cmd_ready;
  logic                 sdram_wr;
  logic [ADDR_BITS-1:0] sdram_addr_x16;
  logic [15:0]          sdram_wdata;
  logic [1:0]           sdram_wmask;
  logic                 sdram_ack;

  modport master (
    output sdram_cmd_valid, sdram_wr, sdram_addr_x16, sdram_wdata, sdram_wmask,
    input  sdram_cmd_ready, sdram_ack
  );

  modport slave (
    input  sdram_cmd_valid, sdram_wr, sdram_addr_x16, sdram_wdata, sdram_wmask,
    output sdram_cmd_ready, sdram_ack
  );
endinterface

// File: rtl/fill_addr_gen.sv
// Raster-order address walker: x/y counters and a line offset accumulator,
// stepped once per accepted command.
module fill_addr_gen
  import fb_fill_pkg::*;
#(
  parameter int ADDR_BITS   = FB_ADDR_BITS,
  parameter int DIM_BITS    = FB_DIM_BITS,
  parameter int STRIDE_BITS = FB_STRIDE_BITS
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   load,
  input  logic                   advance,
  input  logic [ADDR_BITS-1:0]   base,
  input  logic [DIM_BITS-1:0]    width,
  input  logic [DIM_BITS-1:0]    height,
  input  logic [STRIDE_BITS-1:0] stride,
  output logic [ADDR_BITS-1:0]   addr,
  output logic                   last
);

  localparam logic [DIM_BITS-1:0] DIM_ONE = DIM_BITS'(1);

  logic [DIM_BITS-1:0]  x;
  logic [DIM_BITS-1:0]  y;
  logic [ADDR_BITS-1:0] line_off;
  logic                 x_end;

  assign x_end = (x == width - DIM_ONE);
  assign last  = x_end && (y == height - DIM_ONE);
  // Offset from base rather than an absolute line pointer, so base only needs latching once.
  assign addr  = base + line_off + {{(ADDR_BITS-DIM_BITS){1'b0}}, x};

  always_ff @(posedge clk_i) begin
    if (rst_i || load) begin
      x        <= '0;
      y        <= '0;
      line_off <= '0;
    end else if (advance) begin
      if (x_end) begin
        x        <= '0;
        y        <= y + DIM_ONE;
        line_off <= line_off + {{(ADDR_BITS-STRIDE_BITS){1'b0}}, stride};
      end else begin
        x <= x + DIM_ONE;
      end
    end
  end

endmodule

// File: rtl/fb_fill_dma.sv
// Framebuffer fill engine: streams a constant pixel over a rectangle as SDRAM
// write commands, bounding commands in flight and draining acks before done.
module fb_fill_dma
  import fb_fill_pkg::*;
#(
  parameter int ADDR_BITS       = FB_ADDR_BITS,
  parameter int DIM_BITS        = FB_DIM_BITS,
  parameter int STRIDE_BITS     = FB_STRIDE_BITS,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   start_i,
  input  logic                   abort_i,
  input  logic [ADDR_BITS-1:0]   base_x16_i,
  input  logic [DIM_BITS-1:0]    width_i,
  input  logic [DIM_BITS-1:0]    height_i,
  input  logic [STRIDE_BITS-1:0] stride_x16_i,
  input  logic [15:0]            fill_data_i,
  input  logic [1:0]             fill_mask_i,
  output logic                   busy_o,
  output logic                   done_o,
  output logic                   aborted_o,
  fb_fill_dma_if.master          sdram
);

  localparam int                OUT_W   = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [OUT_W-1:0] OUT_MAX = OUT_W'(MAX_OUTSTANDING);
  localparam logic [OUT_W-1:0] OUT_ONE = OUT_W'(1);

  state_t               state, state_n;
  fill_params_t         prm;
  logic [OUT_W-1:0]     outstanding;
  logic                 start_take, empty_req, accept, ack_take, last_pix, cmd_valid;
  logic [ADDR_BITS-1:0] addr;

  assign start_take = (state == IDLE) && start_i;
  assign empty_req  = (width_i == '0) || (height_i == '0);
  assign accept     = cmd_valid && sdram.sdram_cmd_ready;
  // Acks with nothing in flight (e.g. leftovers from before a reset) are dropped.
  assign ack_take   = sdram.sdram_ack && (outstanding != '0);

  fill_addr_gen #(
    .ADDR_BITS  (ADDR_BITS),
    .DIM_BITS   (DIM_BITS),
    .STRIDE_BITS(STRIDE_BITS)
  ) u_addr_gen (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .load   (start_take),
    .advance(accept),
    .base   (prm.base),
    .width  (prm.width),
    .height (prm.height),
    .stride (prm.stride),
    .addr   (addr),
    .last   (last_pix)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) state <= IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:    if (start_i) state_n = empty_req ? DONE : ISSUE;
      ISSUE:   if (abort_i || (accept && last_pix)) state_n = DRAIN;
      DRAIN:   if (outstanding == '0) state_n = DONE;
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Valid only falls through acceptance: outstanding cannot grow without an accept.
  always_comb begin
    cmd_valid = (state == ISSUE) && (outstanding < OUT_MAX);
    busy_o    = (state != IDLE);
  end

  assign sdram.sdram_cmd_valid = cmd_valid;
  assign sdram.sdram_wr        = cmd_valid;
  assign sdram.sdram_addr_x16  = addr;
  assign sdram.sdram_wdata     = prm.data;
  assign sdram.sdram_wmask     = prm.mask;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      prm         <= '0;
      aborted_o   <= 1'b0;
      done_o      <= 1'b0;
      outstanding <= '0;
    end else begin
      done_o <= (state == DONE);
      if (start_take) begin
        prm       <= '{base: base_x16_i, width: width_i, height: height_i,
                       stride: stride_x16_i, data: fill_data_i, mask: fill_mask_i};
        aborted_o <= 1'b0;
      end else if ((state == ISSUE) && abort_i) begin
        aborted_o <= 1'b1;
      end
      unique case ({accept, ack_take})
        2'b10:   outstanding <= outstanding + OUT_ONE;
        2'b01:   outstanding <= outstanding - OUT_ONE;
        default: outstanding <= outstanding;
      endcase
    end
  end

endmodule

// File: tb/tb_fb_fill_dma.sv
// Scoreboard bench for fb_fill_dma: directed runs push expected commands, a
// negedge monitor pops and compares every accepted command.
module tb_fb_fill_dma;

  localparam int MAXO = 4;

  logic        clk = 1'b0;
  logic        rst, start_i, abort_i;
  logic [23:0] base_x16_i;
  logic [10:0] width_i, height_i;
  logic [11:0] stride_x16_i;
  logic [15:0] fill_data_i;
  logic [1:0]  fill_mask_i;
  logic        busy_o, done_o, aborted_o;

  fb_fill_dma_if #(.ADDR_BITS(24)) sd ();

  fb_fill_dma #(.MAX_OUTSTANDING(MAXO)) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .start_i     (start_i),
    .abort_i     (abort_i),
    .base_x16_i  (base_x16_i),
    .width_i     (width_i),
    .height_i    (height_i),
    .stride_x16_i(stride_x16_i),
    .fill_data_i (fill_data_i),
    .fill_mask_i (fill_mask_i),
    .busy_o      (busy_o),
    .done_o      (done_o),
    .aborted_o   (aborted_o),
    .sdram       (sd.master)
  );

  always #5 clk = ~clk;

  int          vectors = 0;
  int          miscompares = 0;
  int          cyc = 0;
  int          acc_total = 0;
  int          done_cnt = 0;
  int          done_cyc = 0;
  int          last_ack_cyc = 0;
  int          start_cyc = 0;
  int          unacked = 0;
  int          ack_delay = 2;
  logic        ready_mode = 1'b0;
  logic        ready_force = 1'b1;
  logic        hold_exempt = 1'b0;
  logic        stray_ack = 1'b0;
  logic [15:0] ack_pipe;
  logic [15:0] cur_data;
  logic [1:0]  cur_mask;
  logic [41:0] exp_q[$];

  initial begin
    cyc = 0;
    forever begin
      @(posedge clk);
      cyc <= cyc + 1;
    end
  end

  // Write acks come back ack_delay cycles after acceptance; stray_ack injects an extra one.
  initial begin
    ack_pipe = '0;
    forever begin
      @(posedge clk);
      ack_pipe <= {ack_pipe[14:0], sd.sdram_cmd_valid & sd.sdram_cmd_ready};
    end
  end
  assign sd.sdram_ack = ack_pipe[ack_delay-1] | stray_ack;

  initial begin
    sd.sdram_cmd_ready = 1'b0;
    forever begin
      @(posedge clk);
      #2;
      sd.sdram_cmd_ready = ready_mode ? 1'($urandom_range(0, 1)) : ready_force;
    end
  end

  initial begin
    logic        prev_stall;
    logic [23:0] prev_addr;
    logic [41:0] exp_v, got_v;
    logic        acc, ack_now;
    prev_stall = 1'b0;
    prev_addr  = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        unacked    = 0;
        prev_stall = 1'b0;
      end else begin
        acc = sd.sdram_cmd_valid && sd.sdram_cmd_ready;
        if (sd.sdram_cmd_valid) begin
          vectors++;
          if (unacked >= MAXO) begin
            miscompares++;
            $display("FAIL outstanding_limit: unacked %0d with cmd_valid, required < %0d", unacked, MAXO);
          end
        end
        if (prev_stall && !hold_exempt) begin
          vectors++;
          if (!sd.sdram_cmd_valid || sd.sdram_addr_x16 !== prev_addr) begin
            miscompares++;
            $display("FAIL cmd_hold: valid=%0b addr=0x%06h, required valid=1 addr=0x%06h",
                     sd.sdram_cmd_valid, sd.sdram_addr_x16, prev_addr);
          end
        end
        if (acc) begin
          acc_total++;
          vectors++;
          got_v = {sd.sdram_addr_x16, sd.sdram_wdata, sd.sdram_wmask};
          if (exp_q.size() == 0) begin
            miscompares++;
            $display("FAIL unexpected_cmd: addr=0x%06h accepted, required none", sd.sdram_addr_x16);
          end else begin
            exp_v = exp_q.pop_front();
            if (got_v !== exp_v || sd.sdram_wr !== 1'b1) begin
              miscompares++;
              $display("FAIL cmd: addr=0x%06h data=0x%04h mask=%b wr=%b, required addr=0x%06h data=0x%04h mask=%b wr=1",
                       got_v[41:18], got_v[17:2], got_v[1:0], sd.sdram_wr,
                       exp_v[41:18], exp_v[17:2], exp_v[1:0]);
            end
          end
        end
        ack_now = sd.sdram_ack && (unacked > 0);
        if (sd.sdram_ack) last_ack_cyc = cyc;
        if (acc) unacked++;
        if (ack_now) unacked--;
        if (done_o) begin
          done_cnt++;
          done_cyc = cyc;
        end
        prev_stall = sd.sdram_cmd_valid && !sd.sdram_cmd_ready;
        prev_addr  = sd.sdram_addr_x16;
      end
    end
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", nm, act, req);
    end
  endtask

  task automatic push_exp(input logic [23:0] a);
    exp_q.push_back({a, cur_data, cur_mask});
  endtask

  task automatic do_start(input logic [23:0] b, input logic [10:0] w, input logic [10:0] h,
                          input logic [11:0] s, input logic exp_valid);
    @(posedge clk);
    #1;
    base_x16_i   = b;
    width_i      = w;
    height_i     = h;
    stride_x16_i = s;
    fill_data_i  = cur_data;
    fill_mask_i  = cur_mask;
    start_i      = 1'b1;
    start_cyc    = cyc;
    @(posedge clk);
    #1;
    start_i = 1'b0;
    chk("busy_after_start", 64'(busy_o), 64'd1);
    chk("first_valid", 64'(sd.sdram_cmd_valid), 64'(exp_valid));
    chk("aborted_cleared", 64'(aborted_o), 64'd0);
  endtask

  task automatic wait_done(input int limit, input logic exp_ab, input string nm);
    int d0 = done_cnt;
    logic got = 1'b0;
    for (int i = 0; i < limit && !got; i++) begin
      @(posedge clk);
      #1;
      if (done_cnt != d0) got = 1'b1;
    end
    chk({nm, "_done_seen"}, 64'(got), 64'd1);
    chk({nm, "_aborted"}, 64'(aborted_o), 64'(exp_ab));
    chk({nm, "_cmds_left"}, 64'(exp_q.size()), 64'd0);
    chk({nm, "_done_after_ack"}, 64'(done_cyc > last_ack_cyc), 64'd1);
    chk({nm, "_busy_low"}, 64'(busy_o), 64'd0);
    repeat (3) @(posedge clk);
    #1;
    chk({nm, "_done_once"}, 64'(done_cnt - d0), 64'd1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int a0;
    rst = 1'b1; start_i = 1'b0; abort_i = 1'b0;
    base_x16_i = '0; width_i = '0; height_i = '0; stride_x16_i = '0;
    fill_data_i = '0; fill_mask_i = '0; cur_data = '0; cur_mask = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", 64'(busy_o), 64'd0);
    chk("rst_done", 64'(done_o), 64'd0);
    chk("rst_valid", 64'(sd.sdram_cmd_valid), 64'd0);
    chk("rst_addr", 64'(sd.sdram_addr_x16), 64'd0);
    chk("rst_wdata_mask", 64'({sd.sdram_wdata, sd.sdram_wmask, aborted_o}), 64'd0);
    rst = 1'b0;
    repeat (2) @(posedge clk);

    // Basic 4x2 fill, ready always high, ack 2 cycles later; a start mid-run must be ignored.
    cur_data = 16'hF800; cur_mask = 2'b11; ack_delay = 2;
    push_exp(24'h000100); push_exp(24'h000101); push_exp(24'h000102); push_exp(24'h000103);
    push_exp(24'h000380); push_exp(24'h000381); push_exp(24'h000382); push_exp(24'h000383);
    do_start(24'h000100, 11'd4, 11'd2, 12'd640, 1'b1);
    base_x16_i = 24'h999999; fill_data_i = 16'h1234; width_i = 11'd1; start_i = 1'b1;
    @(posedge clk);
    #1;
    start_i = 1'b0;
    wait_done(100, 1'b0, "basic");

    // Same rectangle with random ready and slow acks.
    cur_data = 16'h07E0; cur_mask = 2'b01; ack_delay = 10; ready_mode = 1'b1;
    push_exp(24'h000100); push_exp(24'h000101); push_exp(24'h000102); push_exp(24'h000103);
    push_exp(24'h000380); push_exp(24'h000381); push_exp(24'h000382); push_exp(24'h000383);
    do_start(24'h000100, 11'd4, 11'd2, 12'd640, 1'b1);
    wait_done(400, 1'b0, "random_ready");
    ready_mode = 1'b0; ack_delay = 2;

    // Zero-width rectangle: no commands, done two cycles after start.
    cur_data = 16'hAAAA; cur_mask = 2'b10;
    do_start(24'h001000, 11'd0, 11'd5, 12'd16, 1'b0);
    wait_done(20, 1'b0, "empty");
    chk("empty_done_latency", 64'(done_cyc - start_cyc), 64'd2);

    // Abort while idle has no effect.
    @(posedge clk);
    #1;
    abort_i = 1'b1;
    @(posedge clk);
    #1;
    abort_i = 1'b0;
    @(posedge clk);
    #1;
    chk("idle_abort_aborted", 64'(aborted_o), 64'd0);
    chk("idle_abort_busy", 64'(busy_o), 64'd0);

    // Address wraps modulo 2^24.
    cur_data = 16'h001F; cur_mask = 2'b11;
    push_exp(24'hFFFFFE); push_exp(24'hFFFFFF); push_exp(24'h000000); push_exp(24'h000001);
    do_start(24'hFFFFFE, 11'd4, 11'd1, 12'd0, 1'b1);
    wait_done(100, 1'b0, "wrap");

    // Abort a 100x100 fill after exactly 10 accepted commands.
    cur_data = 16'h5A5A; cur_mask = 2'b11;
    for (int i = 0; i < 10; i++) push_exp(24'h002000 + 24'(i));
    a0 = acc_total;
    do_start(24'h002000, 11'd100, 11'd100, 12'd128, 1'b1);
    for (int i = 0; i < 200 && (acc_total - a0) < 10; i++) begin
      @(posedge clk);
      #1;
    end
    hold_exempt = 1'b1; ready_force = 1'b0; abort_i = 1'b1;
    @(posedge clk);
    #1;
    abort_i = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    ready_force = 1'b1; hold_exempt = 1'b0;
    wait_done(100, 1'b1, "abort");
    chk("abort_accept_count", 64'(acc_total - a0), 64'd10);

    // Next start clears aborted_o.
    cur_data = 16'h0F0F; cur_mask = 2'b01;
    push_exp(24'h005000);
    do_start(24'h005000, 11'd1, 11'd1, 12'd0, 1'b1);
    wait_done(50, 1'b0, "after_abort");

    // Reset in the middle of a run, then a stray ack, then a fresh 1x1 run.
    cur_data = 16'hBEEF; cur_mask = 2'b11;
    for (int i = 0; i < 100; i++) push_exp(24'h003000 + 24'(i));
    do_start(24'h003000, 11'd100, 11'd100, 12'd256, 1'b1);
    repeat (6) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    exp_q.delete();
    chk("midrst_busy", 64'(busy_o), 64'd0);
    chk("midrst_valid", 64'(sd.sdram_cmd_valid), 64'd0);
    chk("midrst_addr", 64'(sd.sdram_addr_x16), 64'd0);
    chk("midrst_wdata", 64'({sd.sdram_wdata, sd.sdram_wmask}), 64'd0);
    repeat (12) @(posedge clk);
    #1;
    stray_ack = 1'b1;
    @(posedge clk);
    #1;
    stray_ack = 1'b0;
    @(posedge clk);
    #1;
    chk("stray_ack_busy", 64'({busy_o, done_o, aborted_o}), 64'd0);
    chk("stray_ack_valid", 64'(sd.sdram_cmd_valid), 64'd0);
    cur_data = 16'hC0DE; cur_mask = 2'b10;
    push_exp(24'h004321);
    do_start(24'h004321, 11'd1, 11'd1, 12'd0, 1'b1);
    wait_done(50, 1'b0, "post_reset");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
